// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if -- the bundle that connects two requesters, two response
// consumers and one shared registered right-shifter to shift_arbiter.
//
// Handshake rule, used by every channel in this bundle: a transfer happens
// in the cycle where valid && ready are both 1 at the rising clock edge.
// On the request side, ready is combinational and marks the grant. On the
// response side, valid and its payload hold steady until the transfer.
//
// Signals:
//   req0_*/req1_*     request channels (valid, ready, operand a, shift amount)
//   sh_a/sh_shift     operand and amount issued to the shared shifter
//   sh_out            shifter result, one cycle after issue
//   rsp0_*/rsp1_*     response channels (valid, ready, data, sticky)
// Modports:
//   slave   the arbiter side
//   master  the requesters/consumers/shifter side (the bench)
interface shift_arbiter_if #(
  parameter int WIDTH = 26,
  parameter int SHW   = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [SHW-1:0]   req0_shift;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [SHW-1:0]   req1_shift;

  logic [WIDTH-1:0] sh_a;
  logic [SHW-1:0]   sh_shift;
  logic [WIDTH-1:0] sh_out;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_sticky;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_sticky;

  modport slave (
    input  req0_valid, req0_a, req0_shift,
    input  req1_valid, req1_a, req1_shift,
    input  sh_out, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, sh_a, sh_shift,
    output rsp0_valid, rsp0_data, rsp0_sticky,
    output rsp1_valid, rsp1_data, rsp1_sticky
  );

  modport master (
    output req0_valid, req0_a, req0_shift,
    output req1_valid, req1_a, req1_shift,
    output sh_out, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, sh_a, sh_shift,
    input  rsp0_valid, rsp0_data, rsp0_sticky,
    input  rsp1_valid, rsp1_data, rsp1_sticky
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter -- shares one registered right-shifter between two request
// ports with round-robin arbitration and one response slot per port.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus          shift_arbiter_if.slave (requests, shifter, responses)
//   slot0_state  debug: state of port 0's response slot
//   slot1_state  debug: state of port 1's response slot
//
// Flow: grant in cycle G (sh_a/sh_shift driven combinationally), shifter
// result arrives in G+1 and is captured into the port's slot, rsp_valid is
// visible from G+2 until the consumer takes it.
module shift_arbiter #(
  parameter int WIDTH = 26,
  parameter int SHW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_arbiter_if.slave       bus,
  output logic [1:0]           slot0_state,
  output logic [1:0]           slot1_state
);

  // Per-port slot: FREE -> ISSUED (granted, result in flight) -> HELD
  // (result presented on rsp) -> FREE on the response transfer.
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_ISSUED = 2'd1,
    SLOT_HELD   = 2'd2
  } slot_e;

  slot_e            slot_q [2];
  slot_e            slot_d [2];

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       rsp_fire;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             ptr_q;

  logic [WIDTH-1:0] sel_a;
  logic [SHW-1:0]   sel_shift;
  logic [WIDTH-1:0] mask;
  logic             sel_sticky;

  logic             iss_valid_q;
  logic             iss_tag_q;
  logic             iss_sticky_q;

  logic [WIDTH-1:0] rsp_data_q   [2];
  logic             rsp_sticky_q [2];

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  always_comb begin
    rsp_fire = 2'b00;
    elig     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rsp_fire[i] = (slot_q[i] == SLOT_HELD) && rsp_ready[i];
      // A slot freed by this cycle's transfer is only usable next cycle.
      elig[i]     = req_valid[i] && (slot_q[i] == SLOT_FREE) && !rsp_fire[i] && !reset;
    end
  end

  // On a tie the port other than the last winner takes the grant.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = ptr_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    sel_a     = grant[1] ? bus.req1_a     : bus.req0_a;
    sel_shift = grant[1] ? bus.req1_shift : bus.req0_shift;
    // Bits that fall off the bottom: all of them once shift reaches WIDTH.
    if (int'(sel_shift) >= WIDTH) begin
      mask = '1;
    end else begin
      mask = (WIDTH'(1) << sel_shift) - WIDTH'(1);
    end
    sel_sticky = |(sel_a & mask);
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.sh_a       = (|grant) ? sel_a     : '0;
  assign bus.sh_shift   = (|grant) ? sel_shift : '0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_FREE:   if (grant[i]) slot_d[i] = SLOT_ISSUED;
        SLOT_ISSUED: if (iss_valid_q && (iss_tag_q == 1'(i))) slot_d[i] = SLOT_HELD;
        SLOT_HELD:   if (rsp_fire[i]) slot_d[i] = SLOT_FREE;
        default:     slot_d[i] = SLOT_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= 1'b1;
      iss_valid_q  <= 1'b0;
      iss_tag_q    <= 1'b0;
      iss_sticky_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_q[i]       <= SLOT_FREE;
        rsp_data_q[i]   <= '0;
        rsp_sticky_q[i] <= 1'b0;
      end
    end else begin
      if (|grant) begin
        ptr_q <= grant[1];
      end
      iss_valid_q  <= |grant;
      iss_tag_q    <= grant[1];
      iss_sticky_q <= sel_sticky;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
        if (iss_valid_q && (iss_tag_q == 1'(i))) begin
          rsp_data_q[i]   <= bus.sh_out;
          rsp_sticky_q[i] <= iss_sticky_q;
        end
      end
    end
  end

  assign bus.rsp0_valid  = (slot_q[0] == SLOT_HELD);
  assign bus.rsp1_valid  = (slot_q[1] == SLOT_HELD);
  assign bus.rsp0_data   = rsp_data_q[0];
  assign bus.rsp1_data   = rsp_data_q[1];
  assign bus.rsp0_sticky = rsp_sticky_q[0];
  assign bus.rsp1_sticky = rsp_sticky_q[1];

  assign slot0_state = slot_q[0];
  assign slot1_state = slot_q[1];

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter -- bench for shift_arbiter: reset check, a table of
// single-request vectors, directed multi-cycle sequences (tie, backpressure,
// reset mid-flight) and a randomized phase against a timestamp-based model.
module tb_shift_arbiter;
  localparam int WIDTH = 26;
  localparam int SHW   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] slot0_state;
  logic [1:0] slot1_state;

  int n_tests = 0;
  int n_fail  = 0;

  shift_arbiter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .slot0_state (slot0_state),
    .slot1_state (slot1_state)
  );

  // ---------------- clock / shared shifter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (int'(bus.sh_shift) >= WIDTH) bus.sh_out <= '0;
    else bus.sh_out <= bus.sh_a >> bus.sh_shift;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_req(input int p, input logic v, input logic [WIDTH-1:0] a,
                           input logic [SHW-1:0] s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_shift = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_shift = s;
    end
  endtask

  task automatic idle_inputs();
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction
  function automatic logic get_rv(input int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction
  function automatic logic [WIDTH-1:0] get_data(input int p);
    return (p == 0) ? bus.rsp0_data : bus.rsp1_data;
  endfunction
  function automatic logic get_sticky(input int p);
    return (p == 0) ? bus.rsp0_sticky : bus.rsp1_sticky;
  endfunction

  // Reference arithmetic: plain shift with saturation, sticky bit by bit.
  function automatic logic [WIDTH-1:0] ref_data(input logic [WIDTH-1:0] a, input int s);
    if (s >= WIDTH) return '0;
    return a >> s;
  endfunction
  function automatic logic ref_sticky(input logic [WIDTH-1:0] a, input int s);
    logic st = 1'b0;
    for (int i = 0; i < WIDTH; i++) if (i < s) st |= a[i];
    return st;
  endfunction

  // Reset with requests pending; outputs must be idle and ready held low.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    drive_req(0, 1'b1, 26'h3FFFFFF, 8'd1);
    drive_req(1, 1'b1, 26'h3FFFFFF, 8'd1);
    next_cycle();
    next_cycle();
    settle();
    check("rst_rsp0_valid",  bus.rsp0_valid, 0);
    check("rst_rsp1_valid",  bus.rsp1_valid, 0);
    check("rst_rsp0_data",   bus.rsp0_data, 0);
    check("rst_rsp1_data",   bus.rsp1_data, 0);
    check("rst_rsp0_sticky", bus.rsp0_sticky, 0);
    check("rst_rsp1_sticky", bus.rsp1_sticky, 0);
    check("rst_req0_ready",  bus.req0_ready, 0);
    check("rst_req1_ready",  bus.req1_ready, 0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] exp_data;
    logic             exp_sticky;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vector(input int p, input vec_t v, input int idx);
    drive_req(p, 1'b1, v.a, v.shift);
    settle();
    check($sformatf("vec%0d_ready", idx), get_ready(p), 1);
    check($sformatf("vec%0d_sh_a", idx), bus.sh_a, v.a);
    check($sformatf("vec%0d_sh_shift", idx), bus.sh_shift, v.shift);
    next_cycle();
    drive_req(p, 1'b0, '0, '0);
    settle();
    check($sformatf("vec%0d_rv_early", idx), get_rv(p), 0);
    check($sformatf("vec%0d_sh_idle", idx), bus.sh_a, 0);
    next_cycle();
    settle();
    check($sformatf("vec%0d_rv", idx), get_rv(p), 1);
    check($sformatf("vec%0d_data", idx), get_data(p), v.exp_data);
    check($sformatf("vec%0d_sticky", idx), get_sticky(p), v.exp_sticky);
    next_cycle();
  endtask

  // ---------------- scoreboard (random phase) ----------------
  logic [WIDTH:0] exp_q0[$];
  logic [WIDTH:0] exp_q1[$];

  task automatic random_phase(input int n_cycles);
    bit               reserved [2];
    int               avail    [2];
    bit               ptr;
    int               cyc;
    logic             rv       [2];
    logic             rr       [2];
    logic [WIDTH-1:0] ra       [2];
    logic [SHW-1:0]   rs       [2];
    logic             exp_rv   [2];
    logic             fire     [2];
    logic             elig     [2];
    logic [WIDTH:0]   front;
    int               g;
    int               qsize;

    reserved[0] = 0; reserved[1] = 0;
    avail[0] = 0; avail[1] = 0;
    ptr = 1'b1;
    cyc = 0;
    exp_q0.delete();
    exp_q1.delete();

    for (int k = 0; k < n_cycles; k++) begin
      for (int p = 0; p < 2; p++) begin
        rv[p] = ($urandom_range(0, 9) < 7);
        rr[p] = ($urandom_range(0, 9) < 6);
        ra[p] = WIDTH'($urandom);
        if ($urandom_range(0, 7) == 0) rs[p] = SHW'($urandom_range(0, 255));
        else rs[p] = SHW'($urandom_range(0, 30));
        drive_req(p, rv[p], ra[p], rs[p]);
      end
      bus.rsp0_ready = rr[0];
      bus.rsp1_ready = rr[1];
      settle();

      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = reserved[p] && (cyc >= avail[p]);
        fire[p]   = exp_rv[p] && rr[p];
        elig[p]   = rv[p] && !reserved[p];
      end
      if (elig[0] && elig[1]) g = ptr ? 0 : 1;
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
      else g = -1;

      for (int p = 0; p < 2; p++) begin
        check($sformatf("rnd_ready%0d", p), get_ready(p), (g == p));
        check($sformatf("rnd_rsp_valid%0d", p), get_rv(p), exp_rv[p]);
        if (exp_rv[p]) begin
          qsize = (p == 0) ? exp_q0.size() : exp_q1.size();
          if (qsize == 0) begin
            check($sformatf("rnd_sb_empty%0d", p), 1, 0);
          end else begin
            front = (p == 0) ? exp_q0[0] : exp_q1[0];
            check($sformatf("rnd_data%0d", p), get_data(p), front[WIDTH-1:0]);
            check($sformatf("rnd_sticky%0d", p), get_sticky(p), front[WIDTH]);
          end
        end
      end
      check("rnd_sh_a", bus.sh_a, (g >= 0) ? ra[g] : '0);
      check("rnd_sh_shift", bus.sh_shift, (g >= 0) ? rs[g] : '0);

      next_cycle();

      for (int p = 0; p < 2; p++) begin
        if (fire[p]) begin
          reserved[p] = 0;
          if (p == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
          if (p == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
        end
      end
      if (g >= 0) begin
        reserved[g] = 1;
        avail[g]    = cyc + 2;
        front = {ref_sticky(ra[g], int'(rs[g])), ref_data(ra[g], int'(rs[g]))};
        if (g == 0) exp_q0.push_back(front);
        else exp_q1.push_back(front);
        ptr = (g == 1);
      end
      cyc++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{26'h3FFFFFF, 8'd4,   26'h03FFFFF, 1'b1};
    vecs[1] = '{26'h0000001, 8'd0,   26'h0000001, 1'b0};
    vecs[2] = '{26'h3FFFFFF, 8'd26,  26'h0000000, 1'b1};
    vecs[3] = '{26'h0000000, 8'd200, 26'h0000000, 1'b0};
    vecs[4] = '{26'h2AAAAAA, 8'd1,   26'h1555555, 1'b0};
    vecs[5] = '{26'h0000010, 8'd4,   26'h0000001, 1'b0};
    vecs[6] = '{26'h0000010, 8'd5,   26'h0000000, 1'b1};
    vecs[7] = '{26'h2000000, 8'd25,  26'h0000001, 1'b0};
    vecs[8] = '{26'h3FFFFFF, 8'd25,  26'h0000001, 1'b1};
    vecs[9] = '{26'h0000001, 8'd255, 26'h0000000, 1'b1};

    do_reset();

    // Table: alternate ports so both datapaths see every boundary.
    for (int i = 0; i < 10; i++) begin
      run_vector(i % 2, vecs[i], i);
      run_vector((i + 1) % 2, vecs[i], i + 100);
    end

    // Tie after reset: port 0 first, port 1 the next cycle.
    do_reset();
    drive_req(0, 1'b1, 26'h0000100, 8'd4);
    drive_req(1, 1'b1, 26'h0000200, 8'd4);
    settle();
    check("tie_c0_ready0", bus.req0_ready, 1);
    check("tie_c0_ready1", bus.req1_ready, 0);
    next_cycle();
    settle();
    check("tie_c1_ready0", bus.req0_ready, 0);
    check("tie_c1_ready1", bus.req1_ready, 1);
    next_cycle();
    idle_inputs();
    settle();
    check("tie_c2_rsp0_valid", bus.rsp0_valid, 1);
    check("tie_c2_rsp0_data", bus.rsp0_data, 26'h0000010);
    check("tie_c2_rsp1_valid", bus.rsp1_valid, 0);
    next_cycle();
    settle();
    check("tie_c3_rsp0_valid", bus.rsp0_valid, 0);
    check("tie_c3_rsp1_valid", bus.rsp1_valid, 1);
    check("tie_c3_rsp1_data", bus.rsp1_data, 26'h0000020);
    next_cycle();

    // Backpressure: result held for 5 cycles, regrant one cycle after release.
    do_reset();
    bus.rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 26'h1234567, 8'd8);
    settle();
    check("bp_c0_ready0", bus.req0_ready, 1);
    next_cycle();
    drive_req(0, 1'b1, 26'h3FFFFFF, 8'd0);
    settle();
    check("bp_c1_ready0", bus.req0_ready, 0);
    check("bp_c1_rsp0_valid", bus.rsp0_valid, 0);
    next_cycle();
    for (int c = 2; c < 7; c++) begin
      settle();
      check($sformatf("bp_c%0d_rsp0_valid", c), bus.rsp0_valid, 1);
      check($sformatf("bp_c%0d_data", c), bus.rsp0_data, 26'h0012345);
      check($sformatf("bp_c%0d_sticky", c), bus.rsp0_sticky, 1);
      check($sformatf("bp_c%0d_ready0", c), bus.req0_ready, 0);
      next_cycle();
    end
    bus.rsp0_ready = 1'b1;
    settle();
    check("bp_c7_rsp0_valid", bus.rsp0_valid, 1);
    check("bp_c7_ready0", bus.req0_ready, 0);
    next_cycle();
    settle();
    check("bp_c8_rsp0_valid", bus.rsp0_valid, 0);
    check("bp_c8_ready0", bus.req0_ready, 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();

    // Reset mid-flight: in-flight port 1 result must never appear.
    do_reset();
    drive_req(1, 1'b1, 26'h0000155, 8'd3);
    settle();
    check("rmf_c0_ready1", bus.req1_ready, 1);
    next_cycle();
    reset = 1'b1;
    drive_req(1, 1'b0, '0, '0);
    drive_req(0, 1'b1, 26'h0000F00, 8'd8);
    settle();
    check("rmf_c1_ready0", bus.req0_ready, 0);
    check("rmf_c1_rsp1_valid", bus.rsp1_valid, 0);
    next_cycle();
    settle();
    check("rmf_c2_ready0", bus.req0_ready, 0);
    check("rmf_c2_rsp1_valid", bus.rsp1_valid, 0);
    next_cycle();
    reset = 1'b0;
    drive_req(1, 1'b1, 26'h0000155, 8'd3);
    settle();
    check("rmf_c3_ready0", bus.req0_ready, 1);
    check("rmf_c3_ready1", bus.req1_ready, 0);
    check("rmf_c3_rsp1_valid", bus.rsp1_valid, 0);
    next_cycle();
    idle_inputs();
    for (int c = 4; c < 8; c++) begin
      settle();
      check($sformatf("rmf_c%0d_rsp1_valid", c), bus.rsp1_valid, 0);
      if (c == 5) check("rmf_c5_rsp0_data", bus.rsp0_data, 26'h000000F);
      next_cycle();
    end

    // Randomized traffic against the model.
    do_reset();
    random_phase(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
